// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_nextpc.sv
// rtl/fetch_nextpc.sv - combinational next-PC selection: jr > jump/jal > branch > sequential
module fetch_nextpc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  output logic [31:0] next_pc
);

  logic unused_bits;
  assign unused_bits = ^{rs_data[1:0], instr[OP_MSB:OP_LSB]};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = {rs_data[31:2], 2'b00};
    end else if (jump || jal) begin
      next_pc = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    end else if (pcsrc) begin
      next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - three-state instruction fetch FSM with PC update on retire
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_timeout flag after TIMEOUT_CYC ack-less wait cycles.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_timeout
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         valid_q;
  logic [31:0]  pc_plus4_d;
  logic [31:0]  next_pc_d;

  assign pc_plus4_d  = pc_q + PC_INCR;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

  fetch_nextpc u_nextpc (
    .pc_plus4 (pc_plus4_d),
    .instr    (instr_q),
    .rs_data  (rs_data),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .jal      (jal),
    .jr       (jr),
    .next_pc  (next_pc_d)
  );

  // req/valid are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= S_VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc_q    <= next_pc_d;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          timeout_q;

  assign fetch_timeout = timeout_q;

  // Counter saturates at TIMEOUT_CYC; the flag only clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if ((state_q == S_FETCH) && !imem_ack) begin
      if (wait_cnt_q != CW'(TIMEOUT_CYC)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (wait_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic        jal;
  logic        jr;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .jal         (jal),
    .jr          (jr),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_timeout (fetch_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_fetch(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    step(1);
    imem_ack   = 1'b0;
  endtask

  task automatic do_retire(input logic [31:0] rs, input logic b, input logic j,
                           input logic jl, input logic r);
    rs_data = rs; pcsrc = b; jump = j; jal = jl; jr = r; stall = 1'b0;
    step(1);
    pcsrc = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; stall = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b1;
    pcsrc = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; rs_data = '0;
    step(2);
    checks++;
    if ({imem_req, instr_valid, pc, instr, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state req=%b valid=%b pc=%h instr=%h addr=%h required 0/0/0/0/0",
               imem_req, instr_valid, pc, instr, imem_addr);
    end
  endtask

  task automatic test_first_fetch;
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    reset_n  = 1'b1;
    step(1);
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL first_req req=%b valid=%b addr=%h required 1/0/00000000", imem_req, instr_valid, imem_addr);
    end
    step(1);
    imem_ack = 1'b0;
    checks++;
    if ({instr_valid, imem_req, pc, instr} !== {1'b1, 1'b0, 32'h0, 32'h0800_0010}) begin
      failures++;
      $display("FAIL first_valid valid=%b req=%b pc=%h instr=%h required 1/0/00000000/08000010",
               instr_valid, imem_req, pc, instr);
    end
  endtask

  task automatic test_sequential;
    do_retire(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      failures++;
      $display("FAIL jump_to_40 req=%b addr=%h required 1/00000040", imem_req, imem_addr);
    end
    do_fetch(32'h0000_0020);
    do_retire(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h44) begin
      failures++;
      $display("FAIL seq_retire addr=%h required 00000044", imem_addr);
    end
  endtask

  task automatic test_branch;
    do_fetch(32'h0800_0040);
    do_retire(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_fetch(32'h1000_FFFE);
    checks++;
    if ({pc, pc_plus4} !== {32'h100, 32'h104}) begin
      failures++;
      $display("FAIL branch_setup pc=%h pc_plus4=%h required 00000100/00000104", pc, pc_plus4);
    end
    do_retire(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0FC) begin
      failures++;
      $display("FAIL branch_back pc=%h required 000000fc", pc);
    end
    do_fetch(32'h0);
    do_retire(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h1000_FFFE);
    do_retire(32'h2003, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'h2000) begin
      failures++;
      $display("FAIL jr_over_branch pc=%h required 00002000", pc);
    end
  endtask

  task automatic test_jal;
    do_fetch(32'h0);
    do_retire(32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h0C00_0010);
    checks++;
    if ({pc, pc_plus4} !== {32'h1000_0000, 32'h1000_0004}) begin
      failures++;
      $display("FAIL jal_link pc=%h pc_plus4=%h required 10000000/10000004", pc, pc_plus4);
    end
    do_retire(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pc !== 32'h1000_0040) begin
      failures++;
      $display("FAIL jal_target pc=%h required 10000040", pc);
    end
  endtask

  task automatic test_stall;
    do_fetch(32'hAABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      jr = 1'b1; rs_data = 32'h5555_0000; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      step(1);
      checks++;
      if ({instr_valid, imem_req, pc, instr} !== {1'b1, 1'b0, 32'h1000_0040, 32'hAABB_CCDD}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b req=%b pc=%h instr=%h required 1/0/10000040/aabbccdd",
                 i, instr_valid, imem_req, pc, instr);
      end
    end
    jr = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    step(1);
    stall = 1'b1;
    checks++;
    if ({instr_valid, imem_req, pc} !== {1'b0, 1'b1, 32'h1000_0044}) begin
      failures++;
      $display("FAIL stall_release valid=%b req=%b pc=%h required 0/1/10000044", instr_valid, imem_req, pc);
    end
    step(1);
    checks++;
    if ({imem_req, pc} !== {1'b1, 32'h1000_0044}) begin
      failures++;
      $display("FAIL single_retire req=%b pc=%h required 1/10000044", imem_req, pc);
    end
  endtask

  task automatic test_wrap;
    do_fetch(32'h0);
    do_retire(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL jr_align pc=%h required fffffffc", pc);
    end
    do_fetch(32'h0);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_plus4 pc_plus4=%h required 00000000", pc_plus4);
    end
    do_retire(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({pc, imem_addr} !== {32'h0, 32'h0}) begin
      failures++;
      $display("FAIL wrap_pc pc=%h addr=%h required 00000000/00000000", pc, imem_addr);
    end
  endtask

  task automatic test_ack_withheld;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      checks++;
      if ({imem_req, instr_valid} !== 2'b10) begin
        failures++;
        $display("FAIL wait_hold cycle=%0d req=%b valid=%b required 1/0", i, imem_req, instr_valid);
      end
`ifdef FETCH_TIMEOUT_EN
      if (i == 15 || i == 16) begin
        checks++;
        if (fetch_timeout !== (i == 16)) begin
          failures++;
          $display("FAIL timeout_edge cycle=%0d fetch_timeout=%b required %b", i, fetch_timeout, (i == 16));
        end
      end
`endif
    end
    do_fetch(32'h0000_0001);
    checks++;
    if ({instr_valid, instr} !== {1'b1, 32'h1}) begin
      failures++;
      $display("FAIL late_ack valid=%b instr=%h required 1/00000001", instr_valid, instr);
    end
`ifdef FETCH_TIMEOUT_EN
    checks++;
    if (fetch_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky fetch_timeout=%b required 1", fetch_timeout);
    end
`endif
    do_retire(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    reset_n = 1'b0;
    #2;
    checks++;
    if ({imem_req, instr_valid, pc, instr, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid_wait req=%b valid=%b pc=%h instr=%h addr=%h required 0/0/0/0/0",
               imem_req, instr_valid, pc, instr, imem_addr);
    end
`ifdef FETCH_TIMEOUT_EN
    checks++;
    if (fetch_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset fetch_timeout=%b required 0", fetch_timeout);
    end
`endif
    step(1);
    reset_n = 1'b1;
    step(3);
    checks++;
    if ({imem_req, instr_valid, instr, imem_addr} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL no_stale_valid req=%b valid=%b instr=%h addr=%h required 1/0/0/0",
               imem_req, instr_valid, instr, imem_addr);
    end
  endtask

  task automatic test_reset_mid_stall;
    do_fetch(32'hDEAD_BEEF);
    do_retire(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'hCAFE_0000);
    step(2);
    reset_n = 1'b0;
    #2;
    checks++;
    if ({instr_valid, imem_req, pc, instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid_stall valid=%b req=%b pc=%h instr=%h required 0/0/0/0",
               instr_valid, imem_req, pc, instr);
    end
    step(1);
    reset_n = 1'b1;
    step(2);
    checks++;
    if ({instr_valid, imem_req, pc} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL restart_after_stall valid=%b req=%b pc=%h required 0/1/0", instr_valid, imem_req, pc);
    end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_sequential;
    test_branch;
    test_jal;
    test_stall;
    test_wrap;
    test_ack_withheld;
    test_reset_mid_stall;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
